// File: rtl/bus_mem_responder.sv
// Word-addressed memory slave for the bus valid/ready protocol with programmable latency.
// Optional random stall (LFSR) enabled by defining BUS_RESP_RANDOM_STALL_EN.
module bus_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] read_data_o,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  wstrb_i,
  output logic        err_o,
  output logic [31:0] req_count_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  wait_reg, wait_next;
  logic [29:0] idx_reg, idx_next;
  logic [1:0]  stall;
  logic [4:0]  total;
  logic        enter_resp;
  logic        ready_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic [31:0] count_reg;
  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [29:0] idx);
    return {2'b00, idx} < 32'(DEPTH_WORDS);
  endfunction

`ifdef BUS_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; advances once per accepted request.
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      lfsr_reg <= LFSR_SEED;
    else if (state_reg == IDLE && valid_i)
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
  end

  assign stall = lfsr_reg[1:0];
`else
  assign stall = 2'd0;
`endif

  assign total = 5'(LATENCY) + {3'b000, stall};

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          idx_next  = addr_i[31:2];
          wait_next = total;
          state_next = (total != 5'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wait_reg <= 5'd1)
          state_next = RESP;
        else
          wait_next = wait_reg - 5'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    enter_resp = (state_next == RESP) && (state_reg != RESP);
  end

  // Read data and the range flag are captured on the edge entering RESP so
  // they accompany the ready pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      wait_reg  <= 5'd0;
      idx_reg   <= 30'd0;
      ready_reg <= 1'b0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
      count_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      idx_reg   <= idx_next;
      ready_reg <= enter_resp;
      if (enter_resp) begin
        if (in_range(idx_next)) begin
          rdata_reg <= mem[idx_next[AW-1:0]];
        end else begin
          rdata_reg <= 32'h0;
          err_reg   <= 1'b1;
        end
      end
      if (state_reg == RESP)
        count_reg <= count_reg + 32'd1;
    end
  end

  // Writes use the request inputs as sampled at the edge ending RESP.
  always_ff @(posedge clk_i) begin
    if (state_reg == RESP && wstrb_i != 4'b0000 && in_range(addr_i[31:2])) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b])
          mem[addr_i[AW+1:2]][8*b +: 8] <= write_data_i[8*b +: 8];
      end
    end
  end

  assign ready_o     = ready_reg;
  assign read_data_o = rdata_reg;
  assign err_o       = err_reg;
  assign req_count_o = count_reg;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: a LATENCY=0 instance checked through a
// response queue, plus a LATENCY=3 instance for wait timing and mid-transaction reset.
module tb_bus_mem_responder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_data;
    logic        err;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_done0 = 0;

  // LATENCY = 0 instance
  logic        rst0_n, valid0, ready0, err0;
  logic [31:0] addr0, wdata0, rdata0, cnt0;
  logic [3:0]  wstrb0;

  // LATENCY = 3 instance
  logic        rst3_n, valid3, ready3, err3;
  logic [31:0] addr3, wdata3, rdata3, cnt3;
  logic [3:0]  wstrb3;

  bus_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst0_n), .addr_i(addr0), .valid_i(valid0), .ready_o(ready0),
    .read_data_o(rdata0), .write_data_i(wdata0), .wstrb_i(wstrb0), .err_o(err0),
    .req_count_o(cnt0)
  );

  bus_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst3_n), .addr_i(addr3), .valid_i(valid3), .ready_o(ready3),
    .read_data_o(rdata3), .write_data_i(wdata3), .wstrb_i(wstrb3), .err_o(err3),
    .req_count_o(cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse of dut0 consumes one expected response.
  always @(negedge clk) begin
    if (ready0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready with empty queue, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_data) check("resp_rdata", rdata0, e.rdata);
        check("resp_err", {31'd0, err0}, {31'd0, e.err});
        check("resp_count", cnt0, e.count);
        $display("resp: rdata=%h err=%b count=%0d", rdata0, err0, cnt0);
      end
    end
  end

  task automatic req0(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] exp_rd, input bit chk_data, input logic exp_err);
    exp_t e;
    int lat;
    e.rdata = exp_rd; e.chk_data = chk_data; e.err = exp_err; e.count = 32'(n_done0);
    exp_q.push_back(e);
    n_done0++;
    @(posedge clk); #1;
    addr0 = a; wdata0 = wd; wstrb0 = ws; valid0 = 1'b1;
    lat = 0;
    while (ready0 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      if (ready0 !== 1'b1) lat++;
    end
    check("lat0", 32'(lat), 32'd1);
    $display("req0: addr=%h wdata=%h wstrb=%b latency=%0d", a, wd, ws, lat);
    @(posedge clk); #1;
    valid0 = 1'b0; wstrb0 = 4'b0000;
  endtask

  task automatic req3(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd);
    int lat;
    @(posedge clk); #1;
    addr3 = a; wdata3 = wd; wstrb3 = ws; valid3 = 1'b1;
    lat = 0;
    rd = 32'h0;
    while (ready3 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      if (ready3 !== 1'b1) lat++;
    end
    rd = rdata3;
    check("lat3", 32'(lat), 32'd4);
    $display("req3: addr=%h wdata=%h wstrb=%b latency=%0d rdata=%h", a, wd, ws, lat, rd);
    @(posedge clk); #1;
    valid3 = 1'b0; wstrb3 = 4'b0000;
    @(negedge clk);
    check("ready3_after", {31'd0, ready3}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    rst0_n = 1'b0; valid0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
    rst3_n = 1'b0; valid3 = 1'b0; addr3 = '0; wdata3 = '0; wstrb3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, ready0}, 32'd0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_count", cnt0, 32'd0);

    req0(32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    req0(32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    check("count_after_two", cnt0, 32'd2);
    req0(32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0);
    req0(32'h20, 32'hAABBCCDD, 4'b0101, 32'h11223344, 1'b1, 1'b0);
    req0(32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b1, 1'b0);
    req0(32'h23, 32'h0, 4'h0, 32'h11BB33DD, 1'b1, 1'b0);
    req0(32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0);
    req0(32'hFFC, 32'h0A0B0C0D, 4'hF, 32'h0, 1'b0, 1'b0);
    req0(32'hFFC, 32'h0, 4'h0, 32'h0A0B0C0D, 1'b1, 1'b0);
    check("err_before_oob", {31'd0, err0}, 32'd0);
    req0(32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b1, 1'b1);
    req0(32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    req0(32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1, 1'b1);
    req0(32'h10, 32'h00112233, 4'b1010, 32'hDEADBEEF, 1'b1, 1'b1);
    req0(32'h10, 32'h0, 4'h0, 32'h00AD22EF, 1'b1, 1'b1);
    check("err_sticky", {31'd0, err0}, 32'd1);
    check("count_final", cnt0, 32'd14);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // LATENCY = 3: write, read back, then reset in WAIT during a write.
    req3(32'h40, 32'h55667788, 4'hF, rd);
    req3(32'h40, 32'h0, 4'h0, rd);
    check("lat3_read", rd, 32'h55667788);
    check("count3", cnt3, 32'd2);
    @(posedge clk); #1;
    addr3 = 32'h40; wdata3 = 32'hFFFFFFFF; wstrb3 = 4'hF; valid3 = 1'b1;
    repeat (3) @(negedge clk);
    rst3_n = 1'b0;
    #1;
    check("rst_wait_ready", {31'd0, ready3}, 32'd0);
    check("rst_wait_count", cnt3, 32'd0);
    valid3 = 1'b0; wstrb3 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst3_n = 1'b1;
    req3(32'h40, 32'h0, 4'h0, rd);
    check("rst_word_kept", rd, 32'h55667788);
    check("count3_post_rst", cnt3, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
